ppwm_ctrl: RTL

Controller that configures and sequences a bank of NUM_CH PWM execution cores.
- Holds per-channel program memory and serves each core's instruction fetch.
- Generates the shared prescaled global counter and the period-start pulse.
- Holds the cores in reset while stopped. Software loads programs and the prescaler over a single valid/ready configuration port, then issues START/STOP.

---
 rtl/ppwm_pkg.sv | 25 ++
 rtl/ppwm_prog_mem.sv | 48 ++++
 rtl/ppwm_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ppwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppwm_pkg
// Description : Shared types for the PWM controller: the configuration
//               command encoding and the controller run state.
// Revision    : 1.0 - initial release
// ============================================================================
package ppwm_pkg;

    // Configuration port command encoding (2-bit on the wire)
    typedef enum logic [1:0] {
        CMD_WR_INSTR = 2'd0,
        CMD_WR_PRESC = 2'd1,
        CMD_START    = 2'd2,
        CMD_STOP     = 2'd3
    } cfg_cmd_e;

    // Controller state; RUN releases the cores from reset
    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } ctrl_state_e;

endpackage : ppwm_pkg
`default_nettype wire

// File: rtl/ppwm_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : ppwm_prog_mem
// Description : One channel's program store, 2^PC_WIDTH words of
//               INSTR_WIDTH bits. Synchronous write, combinational read,
//               cleared by the asynchronous reset.
// Ports       : clk, rst      - clock, async active-high reset
//               we_i          - write enable
//               waddr_i       - write address
//               wdata_i       - write data
//               raddr_i       - read address (core program counter)
//               rdata_o       - read data (instruction to core)
// Revision    : 1.0 - initial release
// ============================================================================
module ppwm_prog_mem #(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [PC_WIDTH-1:0]    waddr_i,
    input  logic [INSTR_WIDTH-1:0] wdata_i,
    input  logic [PC_WIDTH-1:0]    raddr_i,
    output logic [INSTR_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** PC_WIDTH;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    // Register array rather than a RAM macro: the whole store must clear
    // on reset, and the core fetch path needs a zero-latency read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle read of the word being written returns the old contents
    assign rdata_o = mem_q[raddr_i];

endmodule : ppwm_prog_mem
`default_nettype wire

// File: rtl/ppwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ppwm_ctrl
// Description : Controller for a bank of NUM_CH PWM execution cores. Holds
//               per-channel program memory, serves instruction fetch,
//               generates the prescaled global counter and period-start
//               pulse, and holds the cores in reset while stopped.
// Ports       : clk, rst          - clock, async active-high reset
//               cfg_valid_i/ready_o - config handshake
//               cfg_cmd_i         - WR_INSTR / WR_PRESC / START / STOP
//               cfg_ch_i, cfg_addr_i, cfg_data_i - command operands
//               running_o         - controller in RUN
//               core_rst_n_o      - sync active-low reset to the cores
//               start_o           - first cycle of each PWM period
//               global_counter_o  - shared global counter
//               core_pc_i         - packed core program counters
//               core_instr_o      - packed fetched instructions
// Revision    : 1.0 - initial release
// ============================================================================
module ppwm_ctrl
    import ppwm_pkg::*;
#(
    parameter  int NUM_CH         = 2,
    parameter  int COUNTER_WIDTH  = 8,
    parameter  int INSTR_WIDTH    = 7,
    parameter  int PC_WIDTH       = 4,
    parameter  int PRESCALE_WIDTH = 8,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [1:0]                    cfg_cmd_i,
    input  logic [CH_W-1:0]               cfg_ch_i,
    input  logic [PC_WIDTH-1:0]           cfg_addr_i,
    input  logic [PRESCALE_WIDTH-1:0]     cfg_data_i,
    output logic                          running_o,
    output logic                          core_rst_n_o,
    output logic                          start_o,
    output logic [COUNTER_WIDTH-1:0]      global_counter_o,
    input  logic [NUM_CH*PC_WIDTH-1:0]    core_pc_i,
    output logic [NUM_CH*INSTR_WIDTH-1:0] core_instr_o
);

    ctrl_state_e                state_q,      state_d;
    logic [PRESCALE_WIDTH-1:0]  prescale_q,   prescale_d;
    logic [PRESCALE_WIDTH-1:0]  presc_cnt_q,  presc_cnt_d;
    logic [COUNTER_WIDTH-1:0]   counter_q,    counter_d;

    cfg_cmd_e w_cmd;
    logic     w_accept;
    logic     w_wr_instr;

    assign w_cmd = cfg_cmd_e'(cfg_cmd_i);

    // While running only STOP may enter; everything else is held by the
    // producer, which is what keeps the period stable during RUN.
    assign cfg_ready_o = (state_q == ST_STOPPED) || (w_cmd == CMD_STOP);
    assign w_accept    = cfg_valid_i && cfg_ready_o;
    assign w_wr_instr  = w_accept && (w_cmd == CMD_WR_INSTR);

    // ------------------------------------------------------------------
    // State / prescaler / counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOPPED;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            counter_q   <= '0;
        end else begin
            state_q     <= state_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            counter_q   <= counter_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        counter_d   = counter_q;

        if (w_accept) begin
            // In RUN the only acceptable command is STOP, so an accepted
            // command always takes precedence over the tick below.
            case (w_cmd)
                CMD_WR_PRESC: prescale_d = cfg_data_i;
                CMD_START: begin
                    if (state_q == ST_STOPPED) begin
                        state_d     = ST_RUN;
                        presc_cnt_d = '0;
                        counter_d   = '0;
                    end
                end
                CMD_STOP: begin
                    state_d     = ST_STOPPED;
                    presc_cnt_d = '0;
                    counter_d   = '0;
                end
                default: ;
            endcase
        end else if (state_q == ST_RUN) begin
            if (presc_cnt_q == prescale_q) begin
                presc_cnt_d = '0;
                counter_d   = counter_q + COUNTER_WIDTH'(1);
            end else begin
                presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign running_o        = (state_q == ST_RUN);
    assign core_rst_n_o     = (state_q == ST_RUN);
    assign global_counter_o = counter_q;
    assign start_o          = (state_q == ST_RUN) && (counter_q == '0)
                              && (presc_cnt_q == '0);

    // ------------------------------------------------------------------
    // Per-channel program memories; out-of-range channels match no copy,
    // so such writes are accepted and silently dropped.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic w_we;

        assign w_we = w_wr_instr && (cfg_ch_i == CH_W'(ch));

        ppwm_prog_mem #(
            .PC_WIDTH    (PC_WIDTH),
            .INSTR_WIDTH (INSTR_WIDTH)
        ) u_mem (
            .clk     (clk),
            .rst     (rst),
            .we_i    (w_we),
            .waddr_i (cfg_addr_i),
            .wdata_i (cfg_data_i[INSTR_WIDTH-1:0]),
            .raddr_i (core_pc_i[ch*PC_WIDTH +: PC_WIDTH]),
            .rdata_o (core_instr_o[ch*INSTR_WIDTH +: INSTR_WIDTH])
        );
    end : g_ch

endmodule : ppwm_ctrl
`default_nettype wire
